br_credit_sender_multi_port: RTL

- Multi-port credit sender: the transmit end of the push-credit interface used by the shared dynamic multi-FIFO and other credit receivers.
- Accepts up to NumWritePorts valid/ready entries per cycle from upstream and forwards them as push_valid/push_data/push_fifo_id.
- Tracks receiver credits and consumes one credit per flit, so the receiver never overflows.
- Handles the sender/receiver reset handshake and returns of up to NumWritePorts credits per cycle.

---
 rtl/br_credit_sender_multi_port.sv | 81 ++++++++
 1 files changed

// File: rtl/br_credit_sender_multi_port.sv
// br_credit_sender_multi_port: in-order multi-lane credit sender with receiver reset handshake
module br_credit_sender_multi_port #(
  parameter int NumWritePorts = 1,
  parameter int NumFifos = 2,
  parameter int Width = 1,
  parameter int MaxCredit = 3,
  parameter int RegisterPushOutputs = 0,
  localparam int PushCreditWidth = $clog2(NumWritePorts + 1),
  localparam int FifoIdWidth = NumFifos > 1 ? $clog2(NumFifos) : 1,
  localparam int CountWidth = $clog2(MaxCredit + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NumWritePorts-1:0]               src_valid,
  output logic [NumWritePorts-1:0]               src_ready,
  input  logic [NumWritePorts*Width-1:0]         src_data,
  input  logic [NumWritePorts*FifoIdWidth-1:0]   src_fifo_id,
  output logic                                   push_sender_in_reset,
  input  logic                                   push_receiver_in_reset,
  input  logic [PushCreditWidth-1:0]             push_credit,
  output logic [NumWritePorts-1:0]               push_valid,
  output logic [NumWritePorts*Width-1:0]         push_data,
  output logic [NumWritePorts*FifoIdWidth-1:0]   push_fifo_id,
  input  logic [CountWidth-1:0]                  credit_initial_push,
  input  logic [CountWidth-1:0]                  credit_withhold_push,
  output logic [CountWidth-1:0]                  credit_count_push,
  output logic [CountWidth-1:0]                  credit_available_push
);
  logic [CountWidth-1:0] count;
  logic [CountWidth:0] next_count;
  logic [NumWritePorts-1:0] grant;
  logic [PushCreditWidth-1:0] sent;
  logic active, ok;
  assign active = !rst && !push_receiver_in_reset;
  assign credit_count_push = count;
  assign credit_available_push = count > credit_withhold_push ? count - credit_withhold_push : '0;
  assign src_ready = grant;
  assign next_count = {1'b0, count} + (CountWidth+1)'(push_credit) - (CountWidth+1)'(sent);
  always_comb begin
    ok = active;
    sent = '0;
    for (int i = 0; i < NumWritePorts; i++) begin
      ok = ok && src_valid[i] && (int'(credit_available_push) > i);
      grant[i] = ok;
      sent = sent + PushCreditWidth'(ok);
    end
  end
  always_ff @(posedge clk) begin
    push_sender_in_reset <= rst;
    count <= active ? next_count[CountWidth-1:0] : credit_initial_push;
    if (!rst) begin
      assert (push_credit <= PushCreditWidth'(NumWritePorts));
      assert (!(push_receiver_in_reset && |push_valid));
      if (active) assert (next_count <= (CountWidth+1)'(MaxCredit));
    end
  end
  generate
    if (RegisterPushOutputs != 0) begin : g_reg
      logic [NumWritePorts-1:0] valid_q;
      logic [NumWritePorts*Width-1:0] data_q;
      logic [NumWritePorts*FifoIdWidth-1:0] id_q;
      always_ff @(posedge clk) begin
        valid_q <= active ? grant : '0;
        data_q <= active ? src_data : '0;
        id_q <= active ? src_fifo_id : '0;
      end
      assign push_valid = valid_q & {NumWritePorts{active}};
      assign push_data = data_q;
      assign push_fifo_id = id_q;
    end else begin : g_comb
      assign push_valid = grant;
      assign push_data = src_data;
      assign push_fifo_id = src_fifo_id;
    end
    for (genvar g = 0; g < NumWritePorts; g++) begin : g_hold
      assert property (@(posedge clk) disable iff (rst)
        src_valid[g] && !src_ready[g] |=> src_valid[g] && $stable(src_data[g*Width +: Width])
          && $stable(src_fifo_id[g*FifoIdWidth +: FifoIdWidth]));
    end
  endgenerate
endmodule
